// File: rtl/ps2_kbd_controller.sv
// ---------------------------------------------------------------------------
// ps2_kbd_controller
//
// Turns the raw byte stream of a PS/2 keyboard receiver into key events for
// the CPU. E0 (extended) and F0 (break) prefixes are folded into a single
// event word, the 8-byte E1 Pause sequence collapses into one event, and
// keyboard status bytes (00, AA, EE, FA, FE, FF) are filtered out. Events are
// held in a small show-ahead FIFO read by the CPU peripheral bus.
//
// Event word: {6'b0, brk, ext, code[7:0]}
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx_byte    byte from receiver, stable from rx_valid rise to next frame
//   rx_valid   receiver byte-ready level; each rising edge is one new byte
//   rd_en      pop the head event (one per cycle while high)
//   evt_data   head event, 0 when the FIFO is empty
//   evt_empty  FIFO empty
//   evt_count  entries held, 0..DEPTH
//   overflow   sticky: an event was dropped because the FIFO was full
//   ovf_clr    clears overflow (a same-cycle drop wins)
//
// Handshake: the CPU side is a show-ahead pop interface. evt_data is valid
// whenever evt_empty is 0; a cycle with rd_en=1 and evt_empty=0 consumes the
// head entry at the next clk edge. rd_en while empty has no effect.
//
// Latency: rx_valid rise sampled at edge N -> sync (N, N+1) -> byte event
// registered at N+2 -> decoded push registered at N+3 -> FIFO write at N+4.
// ---------------------------------------------------------------------------
module ps2_kbd_controller #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rd_en,
  output logic [15:0] evt_data,
  output logic        evt_empty,
  output logic [4:0]  evt_count,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PFX  = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input capture: 2-flop synchronizer, then a registered rising-edge detect.
  // rx_byte is not synchronized; it is stable long before the edge emerges.
  // -------------------------------------------------------------------------
  logic       rv_s1, rv_s2, rv_s2_d;
  logic       byte_evt;
  logic [7:0] byte_q;
  logic       rv_rise;

  assign rv_rise = rv_s2 & ~rv_s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_s1    <= 1'b0;
      rv_s2    <= 1'b0;
      rv_s2_d  <= 1'b0;
      byte_evt <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      rv_s1    <= rx_valid;
      rv_s2    <= rv_s1;
      rv_s2_d  <= rv_s2;
      byte_evt <= rv_rise;
      if (rv_rise) byte_q <= rx_byte;
    end
  end

  // -------------------------------------------------------------------------
  // Byte classification
  // -------------------------------------------------------------------------
  logic is_status;
  logic is_fake_shift;

  always_comb begin
    is_status = 1'b0;
    case (byte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                  is_status = 1'b0;
    endcase
  end

  // Extended 12/59 are the fake shifts some keyboards wrap around E0 keys.
  assign is_fake_shift = (byte_q == 8'h12) || (byte_q == 8'h59);

  // -------------------------------------------------------------------------
  // Sequencer FSM. Output is a registered push request into the FIFO.
  // -------------------------------------------------------------------------
  state_t        state;
  logic          ext, brk;
  logic [2:0]    skip_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          push_vld;
  logic [15:0]   push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip_cnt  <= 3'd0;
      tmo_cnt   <= '0;
      push_vld  <= 1'b0;
      push_data <= 16'h0000;
    end else begin
      push_vld <= 1'b0;
      if (byte_evt) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE, ST_PFX: begin
            if (byte_q == 8'hE0) begin
              ext   <= 1'b1;
              state <= ST_PFX;
            end else if (byte_q == 8'hF0) begin
              brk   <= 1'b1;
              state <= ST_PFX;
            end else if ((state == ST_IDLE) && (byte_q == 8'hE1)) begin
              skip_cnt <= 3'd7;
              state    <= ST_SKIP;
            end else if ((state == ST_IDLE) && is_status) begin
              state <= ST_IDLE;
            end else if (ext && is_fake_shift) begin
              ext   <= 1'b0;
              brk   <= 1'b0;
              state <= ST_IDLE;
            end else begin
              push_vld  <= 1'b1;
              push_data <= {6'b0, brk, ext, byte_q};
              ext       <= 1'b0;
              brk       <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            // The last of the seven trailing Pause bytes emits the event.
            if (skip_cnt == 3'd1) begin
              push_vld  <= 1'b1;
              push_data <= {6'b0, 1'b0, 1'b1, 8'hE1};
              state     <= ST_IDLE;
            end
          end
          default: begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        // A partial sequence that stalls is abandoned silently.
        if (tmo_cnt == TMO_LAST) begin
          state    <= ST_IDLE;
          ext      <= 1'b0;
          brk      <= 1'b0;
          skip_cnt <= 3'd0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Show-ahead FIFO. Pointers carry one extra bit so full and empty are
  // distinguishable and the occupancy is a plain subtraction.
  // -------------------------------------------------------------------------
  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] fill;
  logic        full;
  logic        do_pop, do_push;

  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == (AW+1)'(DEPTH));
  assign evt_empty = (fill == '0);
  assign evt_count = 5'(fill);
  assign evt_data  = evt_empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];

  assign do_pop  = rd_en && !evt_empty;
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_push = push_vld && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !do_push) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  // Storage needs no reset: only entries written since reset are readable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_ps2_kbd_controller.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_controller
//
// Directed bench for ps2_kbd_controller (DEPTH=8, short timeout so the idle
// discard case runs quickly). Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_controller;

  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rd_en;
  logic [15:0] evt_data;
  logic        evt_empty;
  logic [4:0]  evt_count;
  logic        overflow;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  ps2_kbd_controller #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rd_en     (rd_en),
    .evt_data  (evt_data),
    .evt_empty (evt_empty),
    .evt_count (evt_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One receiver frame: rx_valid high for 3 cycles, then low for 3.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Drain remaining pipeline work after the last byte of a sequence.
  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] seq_pause [8];
  logic [15:0] exp_drain [8];

  initial begin
    seq_pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    exp_drain = '{16'h0022, 16'h0023, 16'h0024, 16'h0025,
                  16'h0026, 16'h0027, 16'h0028, 16'h0030};

    // ---------------- reset ----------------
    rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_empty", evt_empty, 1);
    check("rst_count", evt_count, 0);
    check("rst_data", evt_data, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- single make code, latency ----------------
    rx_byte = 8'h1C; rx_valid = 1'b1;        // sampled at next posedge N
    repeat (4) @(negedge clk);               // after N+3
    check("lat_not_yet", evt_empty, 1);
    @(negedge clk);                          // after N+4
    check("lat_empty", evt_empty, 0);
    check("lat_data", evt_data, 16'h001C);
    repeat (3) @(negedge clk);               // level held: no retrigger
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_retrig_count", evt_count, 1);
    pop_one();
    check("pop_empty", evt_empty, 1);
    check("pop_data", evt_data, 0);

    // ---------------- E0 F0 75 ----------------
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); settle();
    check("ext_brk_count", evt_count, 1);
    check("ext_brk_data", evt_data, 16'h0375);
    pop_one();

    // ---------------- F0 1C before timeout ----------------
    send_byte(8'hF0); send_byte(8'h1C); settle();
    check("brk_data", evt_data, 16'h021C);
    pop_one();

    // ---------------- status bytes, fake shift ----------------
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hE0); send_byte(8'h12); settle();
    check("filter_count", evt_count, 0);
    send_byte(8'h1C); settle();
    check("filter_after_count", evt_count, 1);
    check("filter_after_data", evt_data, 16'h001C);
    pop_one();

    // ---------------- Pause sequence ----------------
    for (int i = 0; i < 8; i++) send_byte(seq_pause[i]);
    settle();
    check("pause_count", evt_count, 1);
    check("pause_data", evt_data, 16'h01E1);
    pop_one();

    // ---------------- timeout discards prefix ----------------
    send_byte(8'hF0);
    repeat (TMO + 20) @(negedge clk);
    send_byte(8'h1C); settle();
    check("tmo_count", evt_count, 1);
    check("tmo_data", evt_data, 16'h001C);
    pop_one();
    check("tmo_drained", evt_empty, 1);

    // ---------------- fill and overflow ----------------
    for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i));
    settle();
    check("fill8_count", evt_count, 8);
    check("fill8_ovf", overflow, 0);
    send_byte(8'h29); settle();
    check("ovf_count", evt_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", evt_data, 16'h0021);

    // ---------------- ovf_clr with no push ----------------
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // ---------------- push + pop while full ----------------
    @(negedge clk);
    rx_byte = 8'h30; rx_valid = 1'b1;        // posedge N
    repeat (3) @(negedge clk);               // after N+2
    check("pp_full_before", evt_count, 8);
    @(negedge clk); rd_en = 1'b1;            // pop at N+4 with the push
    @(negedge clk); rd_en = 1'b0; rx_valid = 1'b0;
    check("pp_full_count", evt_count, 8);
    check("pp_full_ovf", overflow, 0);
    check("pp_full_head", evt_data, 16'h0022);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), evt_data, exp_drain[i]);
      pop_one();
    end
    check("drain_empty", evt_empty, 1);
    check("drain_count", evt_count, 0);

    // ---------------- push + pop while empty ----------------
    @(negedge clk);
    rx_byte = 8'h31; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0; rx_valid = 1'b0;
    check("pp_empty_count", evt_count, 1);
    check("pp_empty_data", evt_data, 16'h0031);
    repeat (3) @(negedge clk);
    pop_one();

    // ---------------- async reset with queued events ----------------
    send_byte(8'h1A); send_byte(8'h1B); send_byte(8'h22); settle();
    check("pre_rst_count", evt_count, 3);
    send_byte(8'hE0);                        // leave a prefix pending too
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", evt_empty, 1);
    check("arst_count", evt_count, 0);
    check("arst_data", evt_data, 0);
    @(negedge clk); rst = 1'b0;
    send_byte(8'h1C); settle();
    check("post_rst_data", evt_data, 16'h001C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_controller.md
Name: ps2_kbd_controller

Overview:
- Sequences raw bytes from the PS/2 keyboard receiver into key events for the CPU.
- Folds E0, F0 and E1 prefix sequences into one event word and filters keyboard status bytes.
- Buffers events in a small show-ahead FIFO.
- Sits between the receiver's byte/strobe outputs and the CPU peripheral bus, which reads 16-bit event words.

Parameters:
- DEPTH, 8, FIFO entries; power of two, range 2..16.
- TIMEOUT_CYCLES, 1000000, idle clk cycles after which a partial prefix sequence is discarded (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- rx_byte  in  8  byte from receiver; stable from rx_valid rise until the next frame's start bit
- rx_valid  in  1  receiver byte-ready level; each rising edge means one new byte
- rd_en  in  1  pop the head event (one per clk cycle high)
- evt_data  out  16  head event: {6'b0, brk, ext, code[7:0]}; 0 when empty
- evt_empty  out  1  FIFO empty
- evt_count  out  5  entries held, 0..DEPTH
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async, rst=1): FIFO pointers 0, evt_count=0, evt_empty=1, evt_data=0, overflow=0, FSM=IDLE, sync flops=0, timeout counter=0.
- Input capture: rx_valid passes through a 2-flop synchronizer, then a registered edge detector.
- On a detected rising edge, rx_byte is registered; that cycle is the "byte event".
- A decoded event is written on the cycle after the byte event.
- The rx_valid rising edge sampled at clk edge N gives evt_empty=0 after clk edge N+4 (when the FIFO was empty).
- High levels do not re-trigger; only edges count.
- FSM states: IDLE, PFX (holds ext and brk flags), SKIP (holds a 3-bit count).
- IDLE/PFX, byte E0: set ext, go to PFX.
- IDLE/PFX, byte F0: set brk, go to PFX.
- IDLE only, byte E1: go to SKIP with count=7.
- IDLE only, bytes 00, AA, EE, FA, FE, FF: drop; stay in IDLE.
- IDLE/PFX, any other byte: emit {brk, ext, byte}, clear flags, go to IDLE.
- Fake shift: if ext=1 and the byte is 12 or 59, drop it (no event); clear flags, go to IDLE.
- In PFX, status bytes are treated as ordinary codes.
- SKIP: each byte decrements count.
- SKIP, byte arriving at count=1: emit {brk=0, ext=1, code=E1} (Pause), go to IDLE.
- Timeout counter: cleared on every byte event; increments while FSM≠IDLE.
- Timeout reached (counter == TIMEOUT_CYCLES-1): FSM=IDLE, flags cleared, no event emitted.
- FIFO is show-ahead: evt_data = mem[rd_ptr] whenever evt_empty=0.
- Pop on rd_en && !evt_empty; rd_en while empty is ignored.
- Push when not full: normal write.
- Push when full without a pop: event dropped, overflow<=1, FIFO unchanged.
- Push and pop in the same cycle while full: both occur, count stays DEPTH, no overflow.
- Push and pop in the same cycle while empty: the push takes effect, the pop is ignored, count becomes 1.
- Pointers wrap modulo DEPTH; evt_count is computed from an extra pointer bit.
- Overflow flag: set has priority over ovf_clr in the same cycle.
- rst mid-sequence: the prefix state and all queued events are lost.

Test Plan:
- Byte 1C (rx_valid rise) -> after 4 clk, evt_empty=0, evt_data=0x001C; rd_en 1 cycle -> evt_empty=1, evt_data=0.
- Bytes E0, F0, 75 -> exactly one event, 0x0375; evt_count=1.
- Bytes AA, FA, then E0, 12 -> no events; then 1C -> 0x001C (ext flag not leaked).
- Bytes E1, 14, 77, E1, F0, 14, F0, 77 -> exactly one event, 0x01E1.
- Byte F0, then 1,000,000 idle clk, then 1C -> 0x001C (brk flag discarded).
- 9 make codes with DEPTH=8 and no reads -> evt_count=8, overflow=1, head=first code.
- Full FIFO, push and pop in the same cycle -> count stays 8, overflow unchanged.
- ovf_clr asserted with no push -> overflow=0.
- rst asserted asynchronously with 3 queued events -> evt_empty=1 and evt_count=0 immediately, without waiting for a clk edge.
